// File: rtl/risc_pkg.sv
// Shared instruction-format definitions: opcodes, field positions, loader FSM states
// and the combinational instruction encoder.
package risc_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FCODE_W = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 19;
  localparam int unsigned LABEL_W = 24;

  localparam logic [OPC_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [OPC_W-1:0] OP_ITYPE = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDST  = 4'h2;
  localparam logic [OPC_W-1:0] OP_BREG  = 4'h3;
  localparam logic [OPC_W-1:0] OP_BR    = 4'h4;

  localparam int unsigned OPC_LSB    = 28;
  localparam int unsigned REG1_LSB   = 23;
  localparam int unsigned REG2_LSB   = 18;
  localparam int unsigned SHAMT_LSB  = 13;
  localparam int unsigned IMM_LSB    = 4;
  localparam int unsigned LS_IMM_LSB = 2;
  localparam int unsigned LS_IMM_W   = 16;
  localparam int unsigned LABEL_LSB  = 4;
  localparam int unsigned FCODE_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FCODE_W-1:0] fcode;
    logic [REG_W-1:0]   reg1;
    logic [REG_W-1:0]   reg2;
    logic [REG_W-1:0]   shamt;
    logic [IMM_W-1:0]   immediate;
    logic [LABEL_W-1:0] label;
  } instr_fields_t;

  function automatic logic op_valid(input logic [OPC_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LDST) ||
           (op == OP_BREG)  || (op == OP_BR);
  endfunction

  // Pack the source fields into a 32-bit word; unused bit positions stay zero.
  function automatic logic [WORD_W-1:0] encode_instr(input instr_fields_t f);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = f.opcode;
    case (f.opcode)
      OP_RTYPE: begin
        w[REG1_LSB +: REG_W]    = f.reg1;
        w[REG2_LSB +: REG_W]    = f.reg2;
        w[SHAMT_LSB +: REG_W]   = f.shamt;
        w[FCODE_LSB +: FCODE_W] = f.fcode;
      end
      OP_ITYPE: begin
        w[REG1_LSB +: REG_W]    = f.reg1;
        w[IMM_LSB +: IMM_W]     = f.immediate;
        w[FCODE_LSB +: FCODE_W] = f.fcode;
      end
      OP_LDST: begin
        w[REG1_LSB +: REG_W]      = f.reg1;
        w[REG2_LSB +: REG_W]      = f.reg2;
        w[LS_IMM_LSB +: LS_IMM_W] = f.immediate[LS_IMM_W-1:0];
        w[FCODE_LSB +: 2]         = f.fcode[1:0];
      end
      OP_BREG: begin
        w[REG1_LSB +: REG_W]    = f.reg1;
        w[IMM_LSB +: IMM_W]     = f.label[IMM_W-1:0];
        w[FCODE_LSB +: FCODE_W] = f.fcode;
      end
      OP_BR: begin
        w[LABEL_LSB +: LABEL_W] = f.label;
        w[FCODE_LSB +: FCODE_W] = f.fcode;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words; storage is cleared on reset so the
// head reads zero until the first push.
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction fields, encodes them into 32-bit words, buffers them and writes
// them to instruction memory at consecutive addresses starting from base_addr.
module instr_encoder_loader
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [3:0]        fcode,
  input  logic [4:0]        reg1,
  input  logic [4:0]        reg2,
  input  logic [4:0]        shamt,
  input  logic [18:0]       immediate,
  input  logic [23:0]       label,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic              addr_wrap
);

  state_e            state_q, state_d;
  instr_fields_t     fields;
  logic [WORD_W-1:0] enc_word;
  logic [WORD_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic              accept, push, wr_done, sess_start;
  logic [ADDR_W-1:0] wptr;
  logic              busy_q, done_q;

  assign fields = '{opcode: opcode, fcode: fcode, reg1: reg1, reg2: reg2,
                    shamt: shamt, immediate: immediate, label: label};
  assign enc_word = encode_instr(fields);

  assign sess_start = (state_q == ST_IDLE) && start;
  assign in_ready   = (state_q == ST_LOAD) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && op_valid(opcode);
  assign mem_we     = !fifo_empty;
  assign wr_done    = mem_we && mem_ready;
  assign mem_addr   = wptr;
  assign mem_wdata  = head;
  assign busy       = busy_q;
  assign done       = done_q;

  instr_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc_word),
    .pop   (wr_done),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Session sequencing; drain ends once the buffer holds no pending write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      done_q <= (state_d == ST_DONE);
    end
  end

  // Write pointer advances per completed memory write and wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      addr_wrap <= 1'b0;
    end else if (sess_start) begin
      wptr      <= base_addr;
      addr_wrap <= 1'b0;
    end else if (wr_done) begin
      wptr <= wptr + ADDR_W'(1);
      if (wptr == {ADDR_W{1'b1}}) addr_wrap <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (sess_start) begin
      err_cnt <= '0;
    end else if (accept && !op_valid(opcode) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed-vector bench for instr_encoder_loader with hand-computed expected words.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  fcode = '0;
  logic [4:0]  reg1 = '0;
  logic [4:0]  reg2 = '0;
  logic [4:0]  shamt = '0;
  logic [18:0] immediate = '0;
  logic [23:0] label = '0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;
  logic        addr_wrap;

  int n_chk = 0;
  int n_pass = 0;

  logic [9:0]  cap_addr [64];
  logic [31:0] cap_data [64];
  int wr_n = 0;
  int done_n = 0;
  int acc_n = 0;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .fcode(fcode), .reg1(reg1), .reg2(reg2), .shamt(shamt),
    .immediate(immediate), .label(label),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_cnt(err_cnt), .addr_wrap(addr_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready && wr_n < 64) begin
      cap_addr[wr_n] <= mem_addr;
      cap_data[wr_n] <= mem_wdata;
      wr_n <= wr_n + 1;
    end
    if (rst_n && done) done_n <= done_n + 1;
    if (rst_n && in_valid && in_ready) acc_n <= acc_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic begin_session(input logic [9:0] b);
    @(negedge clk);
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] fc, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] sh, input logic [18:0] imm,
                      input logic [23:0] lab, input logic last);
    int t;
    logic ok;
    @(negedge clk);
    opcode = op; fcode = fc; reg1 = r1; reg2 = r2; shamt = sh;
    immediate = imm; label = lab; in_last = last; in_valid = 1'b1;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(posedge clk);
      ok = in_ready;
      t++;
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t;
    t = 0;
    while (done_n == d0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check(tag, 32'(done_n - d0), 32'd1);
  endtask

  initial begin
    int w0, d0;
    logic [31:0] exp_w;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_err_wrap", 32'({err_cnt, addr_wrap}), 32'd0);
    rst_n = 1'b1;

    // Single R-type word
    w0 = wr_n; d0 = done_n;
    begin_session(10'h010);
    check("r_busy", 32'(busy), 32'd1);
    check("r_in_ready", 32'(in_ready), 32'd1);
    send(4'h0, 4'h1, 5'd3, 5'd5, 5'd2, 19'h0, 24'h0, 1'b1);
    wait_done("r_done", d0);
    check("r_count", 32'(wr_n - w0), 32'd1);
    check("r_addr", 32'(cap_addr[w0]), 32'h010);
    check("r_data", cap_data[w0], 32'h01944001);
    check("r_idle", 32'({busy, done}), 32'd0);

    // LS, branch-reg, branch
    w0 = wr_n; d0 = done_n;
    begin_session(10'h020);
    send(4'h2, 4'h1, 5'd1, 5'd2, 5'd0, 19'h00004, 24'h0, 1'b0);
    send(4'h3, 4'h2, 5'd4, 5'd0, 5'd0, 19'h0, 24'hF80001, 1'b0);
    send(4'h4, 4'h0, 5'd0, 5'd0, 5'd0, 19'h0, 24'h000ABC, 1'b1);
    wait_done("ls_done", d0);
    check("ls_count", 32'(wr_n - w0), 32'd3);
    check("ls_data", cap_data[w0], 32'h20880011);
    check("breg_data", cap_data[w0+1], 32'h32000012);
    check("br_data", cap_data[w0+2], 32'h4000ABC0);
    check("br_addr", 32'(cap_addr[w0+2]), 32'h022);

    // Back-pressure: 6 words, memory stalled
    w0 = wr_n; d0 = done_n;
    mem_ready = 1'b0;
    begin_session(10'h100);
    acc_n = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(4'h1, 4'h0, 5'd0, 5'd0, 5'd0, 19'(i + 1), 24'h0, 1'(i == 5));
      end
      begin
        repeat (14) @(negedge clk);
        check("bp_accepts", 32'(acc_n), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_mem_we", 32'(mem_we), 32'd1);
        check("bp_hold_addr", 32'(mem_addr), 32'h100);
        check("bp_hold_data", mem_wdata, 32'h10000010);
        check("bp_no_write", 32'(wr_n - w0), 32'd0);
        mem_ready = 1'b1;
      end
    join
    wait_done("bp_done", d0);
    check("bp_count", 32'(wr_n - w0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      exp_w = 32'h10000000 | (32'(i + 1) << 4);
      check($sformatf("bp_addr%0d", i), 32'(cap_addr[w0+i]), 32'h100 + 32'(i));
      check($sformatf("bp_data%0d", i), cap_data[w0+i], exp_w);
    end

    // Invalid opcode between two valid words
    w0 = wr_n; d0 = done_n;
    begin_session(10'h200);
    send(4'h0, 4'h1, 5'd3, 5'd5, 5'd2, 19'h0, 24'h0, 1'b0);
    send(4'h7, 4'hF, 5'd31, 5'd31, 5'd31, 19'h7FFFF, 24'hFFFFFF, 1'b0);
    send(4'h4, 4'h0, 5'd0, 5'd0, 5'd0, 19'h0, 24'h000ABC, 1'b1);
    wait_done("inv_done", d0);
    check("inv_count", 32'(wr_n - w0), 32'd2);
    check("inv_addr1", 32'(cap_addr[w0+1]), 32'h201);
    check("inv_data0", cap_data[w0], 32'h01944001);
    check("inv_data1", cap_data[w0+1], 32'h4000ABC0);
    check("inv_err_cnt", 32'(err_cnt), 32'd1);

    // Address wrap
    w0 = wr_n; d0 = done_n;
    begin_session(10'h3FF);
    check("wrap_err_cleared", 32'(err_cnt), 32'd0);
    send(4'h1, 4'hF, 5'd2, 5'd0, 5'd0, 19'h7FFFF, 24'h0, 1'b0);
    send(4'h2, 4'hF, 5'd31, 5'd31, 5'd0, 19'h7FFFF, 24'h0, 1'b1);
    wait_done("wrap_done", d0);
    check("wrap_count", 32'(wr_n - w0), 32'd2);
    check("wrap_addr0", 32'(cap_addr[w0]), 32'h3FF);
    check("wrap_addr1", 32'(cap_addr[w0+1]), 32'h000);
    check("wrap_data0", cap_data[w0], 32'h117FFFFF);
    check("wrap_data1", cap_data[w0+1], 32'h2FFFFFFF);
    check("wrap_flag", 32'(addr_wrap), 32'd1);

    // Invalid opcode carrying in_last still finishes the session
    w0 = wr_n; d0 = done_n;
    begin_session(10'h050);
    check("wrap_cleared", 32'(addr_wrap), 32'd0);
    send(4'h9, 4'h0, 5'd0, 5'd0, 5'd0, 19'h0, 24'h0, 1'b1);
    wait_done("invlast_done", d0);
    check("invlast_count", 32'(wr_n - w0), 32'd0);
    check("invlast_err", 32'(err_cnt), 32'd1);

    // Reset during drain with queued words
    w0 = wr_n;
    mem_ready = 1'b0;
    begin_session(10'h300);
    for (int i = 0; i < 3; i++)
      send(4'h4, 4'h0, 5'd0, 5'd0, 5'd0, 19'h0, 24'(i + 1), 1'(i == 2));
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_busy", 32'({busy, done, in_ready}), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_writes", 32'(wr_n - w0), 32'd0);
    check("mid_rst_idle", 32'({mem_we, busy}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
